// File: rtl/isa_pkg.sv
// Shared RV32I subset definitions: request op codes, major opcodes and funct3 values.
package isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ANDI = 3'd1,
    OP_BNE  = 3'd2,
    OP_SH   = 3'd3,
    OP_LH   = 3'd4
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam int unsigned INSTR_W = 32;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words; head word is presented combinationally.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ADD/ANDI/BNE/SH/LH requests into RV32I words and buffers them for the consumer.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [12:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  input  logic        err_clr,
  output logic [15:0] instr_count
);

  logic [INSTR_W-1:0] word;
  logic               legal;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               err_q, err_d;
  logic [15:0]        count_q, count_d;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (in_op)
      OP_ADD:  word = {7'b0, in_rs2, in_rs1, F3_ADD, in_rd, OPC_OP};
      OP_ANDI: word = {in_imm[11:0], in_rs1, F3_AND, in_rd, OPC_OP_IMM};
      OP_LH:   word = {in_imm[11:0], in_rs1, F3_HALF, in_rd, OPC_LOAD};
      OP_SH:   word = {in_imm[11:5], in_rs2, in_rs1, F3_HALF, in_imm[4:0], OPC_STORE};
      OP_BNE: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BNE,
                 in_imm[4:1], in_imm[11], OPC_BRANCH};
        // Branch offsets are halfword aligned; an odd offset cannot be encoded.
        legal = ~in_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Ready is forced low while reset is held, independent of the FIFO state.
  assign in_ready  = rst_n & ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (out_instr),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // A fresh illegal request takes priority over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (accept && !legal) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign err_illegal = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        err_illegal;
  logic        err_clr = 1'b0;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        m_err = 1'b0;
  logic [15:0] m_count = '0;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .err_illegal (err_illegal),
    .err_clr     (err_clr),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_illegal(input int unsigned op, input int unsigned imm);
    return (op > 4) || (op == 2 && (imm % 2) == 1);
  endfunction

  // Words assembled with shifts and masks straight from the RV32I field layouts.
  function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned imm);
    int unsigned w;
    w = 0;
    case (op)
      0: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (7 << 12) | (rd << 7) | 32'h13;
      4: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (1 << 12) | (rd << 7) | 32'h03;
      3: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (1 << 12) |
             ((imm & 32'h1F) << 7) | 32'h23;
      2: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (1 << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 1) << 7) | 32'h63;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_instr", out_instr, exp_q[0]);
    check("err_illegal", 32'(err_illegal), 32'(m_err));
    check("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  // One clock: decide transfers from the model's view, advance model, compare.
  task automatic cycle();
    bit          acc, pop, ill;
    logic [31:0] w;
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() > 0);
    ill = ref_illegal(in_op, in_imm);
    w   = ref_encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(exp_q.pop_front());
      m_count++;
    end
    if (acc && !ill) exp_q.push_back(w);
    if (acc && ill) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    check_outputs();
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [12:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_err   = 1'b0;
    m_count = '0;
  endtask

  initial begin
    // Power-on reset
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(in_ready), 32'd1);

    // ADD
    out_ready = 1'b1;
    drive_req(3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    cycle();
    check("add_word", out_instr, 32'h002081B3);
    idle(1);
    check("add_count", 32'(instr_count), 32'd1);

    // ANDI and LH
    drive_req(3'd1, 5'd5, 5'd6, 5'd9, 13'h0FF);
    cycle();
    check("andi_word", out_instr, 32'h0FF37293);
    drive_req(3'd4, 5'd7, 5'd2, 5'd31, 13'h1FFC);
    cycle();
    check("lh_word", out_instr, 32'hFFC11383);
    idle(1);

    // BNE legal and misaligned
    drive_req(3'd2, 5'd17, 5'd1, 5'd2, 13'h1FF8);
    cycle();
    check("bne_word", out_instr, 32'hFE209CE3);
    idle(1);
    drive_req(3'd2, 5'd0, 5'd1, 5'd2, 13'h1FF9);
    cycle();
    check("bne_odd_noout", 32'(out_valid), 32'd0);
    check("bne_odd_err", 32'(err_illegal), 32'd1);
    in_valid = 1'b0;
    err_clr  = 1'b1;
    cycle();
    err_clr  = 1'b0;

    // Backpressure: three requests into a two-deep buffer
    out_ready = 1'b0;
    drive_req(3'd0, 5'd10, 5'd11, 5'd12, 13'd0);
    cycle();
    drive_req(3'd3, 5'd0, 5'd4, 5'd5, 13'h0ABC);
    cycle();
    check("bp_full", 32'(in_ready), 32'd0);
    drive_req(3'd1, 5'd8, 5'd9, 5'd0, 13'h0123);
    cycle();
    cycle();
    check("bp_hold", out_instr, ref_encode(0, 10, 11, 12, 0));
    out_ready = 1'b1;
    cycle();
    check("bp_second", out_instr, ref_encode(3, 0, 4, 5, 13'h0ABC));
    cycle();
    in_valid = 1'b0;
    check("bp_third", out_instr, ref_encode(1, 8, 9, 0, 13'h0123));
    idle(2);

    // Illegal op coincident with clear
    drive_req(3'd6, 5'd1, 5'd1, 5'd1, 13'd0);
    err_clr = 1'b1;
    cycle();
    check("ill_wins_clr", 32'(err_illegal), 32'd1);
    in_valid = 1'b0;
    cycle();
    err_clr = 1'b0;
    check("clr_alone", 32'(err_illegal), 32'd0);

    // Reset with two words buffered
    out_ready = 1'b0;
    drive_req(3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    cycle();
    drive_req(3'd4, 5'd4, 5'd5, 5'd6, 13'h0040);
    cycle();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(instr_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_rd     = 5'($urandom_range(0, 31));
      in_rs1    = 5'($urandom_range(0, 31));
      in_rs2    = 5'($urandom_range(0, 31));
      in_imm    = 13'($urandom_range(0, 8191));
      if (in_op == 3'd2 && $urandom_range(0, 3) != 0) in_imm[0] = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      cycle();
    end
    err_clr   = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a request.
REQ-006 SHALL have port in_op  input  3  0=ADD, 1=ANDI, 2=BNE, 3=SH, 4=LH, 5-7 illegal.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 SHALL have port in_imm  input  13  signed immediate (bits 11:0 for I/S-type; 12:0 byte offset for BNE).
REQ-009 SHALL have port out_valid  input-side  output  1  out_instr valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word.
REQ-011 SHALL have port out_instr  output  32  encoded RV32I instruction word.
REQ-012 SHALL have port err_illegal  output  1  sticky illegal-request flag.
REQ-013 SHALL have port err_clr  input  1  clears err_illegal.
REQ-014 SHALL have port instr_count  output  16  count of words delivered on output.

Function
REQ-015 SHALL complete input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 SHALL drive in_ready = FIFO not full; no push when full even if popping same cycle.
REQ-017 SHALL encode ADD as {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}.
REQ-018 SHALL encode ANDI as {imm[11:0], rs1, 3'b111, rd, 7'b0010011}.
REQ-019 SHALL encode LH as {imm[11:0], rs1, 3'b001, rd, 7'b0000011}.
REQ-020 SHALL encode SH as {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011}.
REQ-021 SHALL encode BNE as {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
REQ-022 SHALL ignore unused fields per format (rd for SH/BNE, rs2 for ANDI/LH, imm for ADD, imm[12] for non-BNE).
REQ-023 SHALL treat in_op 5-7, and BNE with imm[0]=1, as illegal: handshake completes, nothing pushed, err_illegal set next cycle.
REQ-024 SHALL give latency one cycle: request accepted in cycle N into empty FIFO -> out_valid high in cycle N+1.
REQ-025 SHALL hold out_instr stable while out_valid && !out_ready.
REQ-026 SHALL deliver words in acceptance order; simultaneous push and pop when not full SHALL keep occupancy unchanged.
REQ-027 SHALL increment instr_count on each output transfer, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL let a new illegal request win over err_clr in the same cycle (flag stays 1).

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: FIFO empty, out_valid=0, in_ready=0 while asserted, out_instr=0, err_illegal=0, instr_count=0.
REQ-030 SHALL discard buffered words on reset mid-operation; in_ready=1 first cycle after deassertion.

Structure
REQ-031 SHALL place in_op encodings, opcode and funct3 constants in shared package isa_pkg, reused by the control unit.
REQ-032 SHALL implement buffering as sub-module instr_fifo (synchronous FIFO, width 32, depth FIFO_DEPTH); encoding logic stays combinational in instr_encoder.

Verification
REQ-033 SHALL test ADD rd=3 rs1=1 rs2=2, out_ready=1 -> out_instr=0x002081B3 next cycle, instr_count=1.
REQ-034 SHALL test ANDI rd=5 rs1=6 imm=0x0FF -> 0x0FF37293; LH rd=7 rs1=2 imm=-4 -> 0xFFC11383.
REQ-035 SHALL test BNE rs1=1 rs2=2 imm=-8 -> 0xFE209CE3; BNE imm=-7 -> no output, err_illegal=1.
REQ-036 SHALL test out_ready=0, three back-to-back requests (depth 2) -> in_ready low after two, words held stable, order preserved after release.
REQ-037 SHALL test in_op=6 coincident with err_clr -> err_illegal stays 1; err_clr alone next cycle -> 0.
REQ-038 SHALL test rst_n pulse with 2 words buffered -> out_valid=0, instr_count=0 immediately, no stale word emitted afterwards.
